// File: rtl/display_capture.sv
// display_capture: receive side of a multiplexed seven-segment display.
// Samples the active-low segment and anode buses, decodes each stable digit
// back to a hex nibble and emits the reassembled word with a one-cycle
// frame_valid pulse once every digit position has been captured.
module display_capture #(
   parameter int number_input_width = 32,
   parameter int SETTLE_CYCLES      = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [7:0]                    sevensegment,
   input  logic [7:0]                    AN,
   output logic [number_input_width-1:0] numero_binario,
   output logic                          frame_valid,
   output logic                          frame_error
);

   localparam int NUM_DIGITS = number_input_width / 4;
   localparam int CW         = $clog2(SETTLE_CYCLES + 1);

   localparam logic [CW-1:0] STAB_MAX = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0] STAB_CAP = CW'(SETTLE_CYCLES - 1);

   // Anode positions that belong to this word; higher anodes read as idle.
   localparam logic [8:0] SEL_FULL = (9'd1 << NUM_DIGITS) - 9'd1;
   localparam logic [7:0] SEL_MASK = SEL_FULL[7:0];

   // Active-low {g..a} pattern to {valid, nibble}; unknown patterns give 0.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         7'h40:   res = {1'b1, 4'h0};
         7'h79:   res = {1'b1, 4'h1};
         7'h24:   res = {1'b1, 4'h2};
         7'h30:   res = {1'b1, 4'h3};
         7'h19:   res = {1'b1, 4'h4};
         7'h12:   res = {1'b1, 4'h5};
         7'h02:   res = {1'b1, 4'h6};
         7'h78:   res = {1'b1, 4'h7};
         7'h00:   res = {1'b1, 4'h8};
         7'h10:   res = {1'b1, 4'h9};
         7'h08:   res = {1'b1, 4'hA};
         7'h03:   res = {1'b1, 4'hB};
         7'h46:   res = {1'b1, 4'hC};
         7'h21:   res = {1'b1, 4'hD};
         7'h06:   res = {1'b1, 4'hE};
         7'h0E:   res = {1'b1, 4'hF};
         default: res = {1'b0, 4'h0};
      endcase
      return res;
   endfunction

   // Registered state and next-state values
   logic [14:0]                   in_q,       in_d;
   logic [CW-1:0]                 stab_q,     stab_d;
   logic                          captured_q, captured_d;
   logic [NUM_DIGITS-1:0]         mask_q,     mask_d;
   logic                          err_q,      err_d;
   logic [number_input_width-1:0] shadow_q,   shadow_d;
   logic [number_input_width-1:0] numero_q,   numero_d;
   logic                          valid_q,    valid_d;
   logic                          ferr_q,     ferr_d;

   // Combinational helpers
   logic [14:0]           sample_s;
   logic                  same_s;
   logic [7:0]            an_eff_s;
   logic [7:0]            low_s;
   logic                  blank_s;
   logic                  onehot_s;
   logic                  multi_s;
   logic                  stable_hit_s;
   logic                  capture_s;
   logic                  multi_err_s;
   logic [4:0]            dec_s;
   logic                  dec_err_s;
   logic [NUM_DIGITS-1:0] cap_vec_s;
   logic [NUM_DIGITS-1:0] mask_next_s;
   logic                  err_next_s;
   logic                  frame_done_s;
   logic                  unused_dp_s;

   // The decimal point carries no information for the reconstructed word.
   assign unused_dp_s = sevensegment[7];
   assign sample_s    = {AN, sevensegment[6:0]};

   // Classify the registered anode bus and decide whether this edge captures.
   always_comb begin
      same_s       = (sample_s == in_q);
      an_eff_s     = in_q[14:7] | ~SEL_MASK;
      low_s        = ~an_eff_s;
      blank_s      = (low_s == 8'd0);
      onehot_s     = !blank_s && ((low_s & (low_s - 8'd1)) == 8'd0);
      multi_s      = !blank_s && !onehot_s;
      stable_hit_s = same_s && (stab_q == STAB_CAP) && !captured_q;
      capture_s    = stable_hit_s && onehot_s;
      multi_err_s  = stable_hit_s && multi_s;
      dec_s        = decode_seg(in_q[6:0]);
      dec_err_s    = !dec_s[4];
      // For a one-hot select the active-low anodes are the digit select vector.
      if (capture_s) begin
         cap_vec_s = low_s[NUM_DIGITS-1:0];
      end else begin
         cap_vec_s = '0;
      end
      mask_next_s  = mask_q | cap_vec_s;
      err_next_s   = err_q | multi_err_s | (capture_s & dec_err_s);
      frame_done_s = capture_s && (&mask_next_s);
   end

   // Input sampling, stability counting and once-per-dwell capture flag.
   always_comb begin
      in_d       = sample_s;
      stab_d     = stab_q;
      captured_d = captured_q;
      if (!same_s) begin
         stab_d     = '0;
         captured_d = 1'b0;
      end else begin
         if (stab_q != STAB_MAX) begin
            stab_d = stab_q + CW'(1);
         end else begin
            stab_d = stab_q;
         end
         if (capture_s || multi_err_s) begin
            captured_d = 1'b1;
         end else begin
            captured_d = captured_q;
         end
      end
   end

   // Shadow word update, frame assembly and output pulse generation.
   always_comb begin
      shadow_d = shadow_q;
      numero_d = numero_q;
      mask_d   = mask_next_s;
      err_d    = err_next_s;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (cap_vec_s[j]) begin
            shadow_d[4*j +: 4] = dec_s[3:0];
         end else begin
            shadow_d[4*j +: 4] = shadow_q[4*j +: 4];
         end
      end
      if (frame_done_s) begin
         numero_d = shadow_d;
         valid_d  = 1'b1;
         ferr_d   = err_next_s;
         mask_d   = '0;
         err_d    = 1'b0;
      end else begin
         numero_d = numero_q;
      end
   end

   // State register with synchronous reset; a partial frame is discarded.
   always_ff @(posedge clock) begin
      if (reset) begin
         in_q       <= '1;
         stab_q     <= '0;
         captured_q <= 1'b0;
         mask_q     <= '0;
         err_q      <= 1'b0;
         shadow_q   <= '0;
         numero_q   <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         in_q       <= in_d;
         stab_q     <= stab_d;
         captured_q <= captured_d;
         mask_q     <= mask_d;
         err_q      <= err_d;
         shadow_q   <= shadow_d;
         numero_q   <= numero_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
      end
   end

   assign numero_binario = numero_q;
   assign frame_valid    = valid_q;
   assign frame_error    = ferr_q;

endmodule

// File: tb/tb_display_capture.sv
// Bench for display_capture: directed and randomized digit dwells checked
// against a frame-level reference model (per-digit nibbles plus a coverage set).
module tb_display_capture;

   localparam int SC = 4;

   localparam logic [6:0] SEG_TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  seg_i, an_i;
   logic [31:0] numero;
   logic        fvalid, ferror;
   logic [7:0]  seg16, an16;
   logic [15:0] numero16;
   logic        fvalid16, ferror16;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [3:0]  m_shadow [8];
   logic [7:0]  m_mask;
   logic        m_err;
   logic [31:0] last_val;
   logic [31:0] exp_val [$];
   logic        exp_err [$];
   logic [31:0] obs_val [$];
   logic        obs_err [$];
   logic [15:0] obs16_val [$];
   logic        obs16_err [$];

   display_capture #(.number_input_width(32), .SETTLE_CYCLES(SC)) dut (
      .clock(clock), .reset(reset), .sevensegment(seg_i), .AN(an_i),
      .numero_binario(numero), .frame_valid(fvalid), .frame_error(ferror));

   display_capture #(.number_input_width(16), .SETTLE_CYCLES(SC)) dut16 (
      .clock(clock), .reset(reset), .sevensegment(seg16), .AN(an16),
      .numero_binario(numero16), .frame_valid(fvalid16), .frame_error(ferror16));

   always #5 clock = ~clock;

   // collect delivered frames away from the active edge
   always @(negedge clock) begin
      if (fvalid === 1'b1) begin
         obs_val.push_back(numero);
         obs_err.push_back(ferror);
      end
      if (fvalid16 === 1'b1) begin
         obs16_val.push_back(numero16);
         obs16_err.push_back(ferror16);
      end
   end

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int lookup(input logic [6:0] seg);
      int r = -1;
      for (int n = 0; n < 16; n++) if (SEG_TBL[n] == seg) r = n;
      return r;
   endfunction

   function automatic logic [6:0] bad_seg();
      logic [6:0] p = 7'h7F;
      for (int t = 0; t < 200; t++) begin
         p = 7'($urandom);
         if (lookup(p) < 0) break;
      end
      if (lookup(p) >= 0) p = 7'h7F;
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_shadow[i] = 4'h0;
      m_mask = 8'h00;
      m_err  = 1'b0;
   endtask

   // a dwell counts only if held long enough to pass the settle filter
   task automatic model_dwell(input logic [7:0] an, input logic [6:0] seg, input int cycles);
      int zeros, pos, nib;
      logic [31:0] word;
      if (cycles >= SC + 1) begin
         zeros = 0;
         pos   = 0;
         for (int i = 0; i < 8; i++) if (!an[i]) begin zeros++; pos = i; end
         if (zeros > 1) begin
            m_err = 1'b1;
         end else if (zeros == 1) begin
            nib = lookup(seg);
            if (nib < 0) begin
               m_shadow[pos] = 4'h0;
               m_err = 1'b1;
            end else begin
               m_shadow[pos] = nib[3:0];
            end
            m_mask[pos] = 1'b1;
            if (m_mask == 8'hFF) begin
               word = 32'd0;
               for (int i = 0; i < 8; i++) word[4*i +: 4] = m_shadow[i];
               exp_val.push_back(word);
               exp_err.push_back(m_err);
               last_val = word;
               m_mask = 8'h00;
               m_err  = 1'b0;
            end
         end
      end
   endtask

   // hold one pattern, then a single idle cycle so dwells never merge
   task automatic dwell(input logic [7:0] an, input logic [7:0] seg, input int cycles);
      an_i  = an;
      seg_i = seg;
      repeat (cycles) @(posedge clock);
      #1;
      model_dwell(an, seg[6:0], cycles);
      an_i  = 8'hFF;
      seg_i = 8'hFF;
      @(posedge clock);
      #1;
   endtask

   task automatic digit(input int pos, input logic [6:0] seg, input int cycles);
      logic [7:0] sel = 8'd1 << pos;
      dwell(~sel, {1'($urandom), seg}, cycles);
   endtask

   task automatic send_word(input logic [31:0] v, input int mode, input int len);
      int ord [8];
      int j, t;
      for (int i = 0; i < 8; i++) ord[i] = (mode == 1) ? 7 - i : i;
      if (mode == 2) begin
         for (int i = 7; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
         end
      end
      for (int k = 0; k < 8; k++) digit(ord[k], SEG_TBL[v[4*ord[k] +: 4]], len);
   endtask

   task automatic random_frame(input int extra);
      logic [31:0] v = $urandom;
      int p, q;
      logic [7:0] s1, s2;
      int ord [8];
      int j, t;
      for (int i = 0; i < 8; i++) ord[i] = i;
      for (int i = 7; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int k = 0; k < 8; k++) begin
         p = ord[k];
         if ($urandom_range(3, 0) == 0)
            digit($urandom_range(7, 0), SEG_TBL[$urandom_range(15, 0)], $urandom_range(SC, 1));
         if ($urandom_range(15, 0) == 0) begin
            q  = (p + 1 + $urandom_range(6, 0)) % 8;
            s1 = 8'd1 << p;
            s2 = 8'd1 << q;
            dwell(~(s1 | s2), {1'b1, SEG_TBL[v[4*p +: 4]]}, SC + 1 + $urandom_range(extra, 0));
         end
         if ($urandom_range(15, 0) == 0)
            digit(p, bad_seg(), SC + 1 + $urandom_range(extra, 0));
         else
            digit(p, SEG_TBL[v[4*p +: 4]], SC + 1 + $urandom_range(extra, 0));
         if ($urandom_range(7, 0) == 0)
            digit(p, SEG_TBL[$urandom_range(15, 0)], SC + 1 + $urandom_range(extra, 0));
      end
   endtask

   // compare delivered frames against the model, then the held output word
   task automatic check_frames(input string tag);
      int n;
      repeat (4) @(posedge clock);
      #1;
      cmp({tag, "_count"}, obs_val.size(), exp_val.size());
      n = (obs_val.size() < exp_val.size()) ? obs_val.size() : exp_val.size();
      for (int i = 0; i < n; i++) begin
         cmp({tag, "_value"}, obs_val[i], exp_val[i]);
         cmp({tag, "_error"}, {31'd0, obs_err[i]}, {31'd0, exp_err[i]});
      end
      @(negedge clock);
      cmp({tag, "_hold"}, numero, last_val);
      @(posedge clock);
      #1;
      obs_val.delete(); obs_err.delete();
      exp_val.delete(); exp_err.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      last_val = 32'd0;
      @(negedge clock);
      cmp("reset_numero", numero, 32'd0);
      cmp("reset_valid", {31'd0, fvalid}, 32'd0);
      cmp("reset_error", {31'd0, ferror}, 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [3:0] lo;
      logic [7:0] sel;
      logic [15:0] w16;
      reset = 1'b1;
      an_i  = 8'hFF; seg_i = 8'hFF;
      an16  = 8'hFF; seg16 = 8'hFF;
      model_reset();
      last_val = 32'd0;
      repeat (2) @(posedge clock);
      #1;
      do_reset();

      // full frames in both digit orders
      send_word(32'h12345678, 0, 10);
      check_frames("frame_asc");
      send_word(32'hDEADBEEF, 1, 10);
      check_frames("frame_desc");

      // short pattern is filtered, the settled one is kept
      digit(3, 7'h79, SC);
      digit(3, 7'h30, 10);
      for (int i = 0; i < 8; i++) if (i != 3) digit(i, SEG_TBL[0], 10);
      check_frames("glitch");

      // invalid pattern on digit 5
      for (int i = 0; i < 8; i++) digit(i, (i == 5) ? 7'h7F : SEG_TBL[i + 8], 10);
      check_frames("bad_pattern");

      // multi-select flags an error but leaves the coverage set alone
      dwell(8'hF3, {1'b1, SEG_TBL[9]}, 12);
      for (int i = 0; i < 8; i++) if (i != 2 && i != 3) digit(i, SEG_TBL[i], 10);
      check_frames("multi_partial");
      digit(2, SEG_TBL[2], 10);
      digit(3, SEG_TBL[3], 10);
      check_frames("multi_select");

      // reset mid-frame discards the partial word
      for (int i = 0; i < 5; i++) digit(i, SEG_TBL[15 - i], 10);
      check_frames("partial");
      do_reset();
      for (int i = 0; i < 3; i++) digit(i, SEG_TBL[i + 4], 10);
      check_frames("after_reset_partial");
      send_word(32'hCAFE0135, 2, 10);
      check_frames("after_reset");

      // long blank, overwrite, long dwell
      dwell(8'hFF, 8'h00, 100);
      digit(0, SEG_TBL[1], 10);
      digit(1, SEG_TBL[1], 10);
      digit(2, 7'h24, 10);
      digit(3, SEG_TBL[3], 10);
      digit(2, 7'h0E, 10);
      for (int i = 4; i < 8; i++) digit(i, SEG_TBL[i], 10);
      check_frames("overwrite");
      digit(0, SEG_TBL[6], 1000);
      for (int i = 1; i < 8; i++) digit(i, SEG_TBL[8 - i], 10);
      check_frames("long_dwell");

      // randomized frames, including minimum-length back-to-back dwells
      for (int f = 0; f < 24; f++) random_frame((f % 4 == 0) ? 0 : 10);
      check_frames("random");

      // 16-bit instance: upper anodes ignored
      w16 = 16'hA5C3;
      an16 = 8'h0F; seg16 = {1'b1, SEG_TBL[4]};
      repeat (12) @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         sel = 8'd1 << i;
         lo  = ~sel[3:0];
         an16  = {4'($urandom), lo};
         seg16 = {1'b0, SEG_TBL[w16[4*i +: 4]]};
         repeat (10) @(posedge clock);
         #1;
         an16 = 8'hFF; seg16 = 8'hFF;
         @(posedge clock);
         #1;
      end
      repeat (4) @(posedge clock);
      #1;
      cmp("w16_count", obs16_val.size(), 32'd1);
      if (obs16_val.size() > 0) begin
         cmp("w16_value", {16'd0, obs16_val[0]}, 32'h0000A5C3);
         cmp("w16_error", {31'd0, obs16_err[0]}, 32'd0);
      end
      @(negedge clock);
      cmp("w16_hold", {16'd0, numero16}, 32'h0000A5C3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
